// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu_ctrl_pkg : shared types for the pipeline sequencing controller   |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package cpu_ctrl_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SLEEP = 2'd1,
    IRQ   = 2'd2
  } ctrl_state_e;

  typedef enum logic [2:0] {
    SEQ    = 3'd0,
    TARGET = 3'd1,
    EX_PC4 = 3'd2,
    MTVEC  = 3'd3,
    MEPC   = 3'd4,
    HOLD   = 3'd5
  } pc_sel_e;

  // x0 is hardwired to zero, so a load targeting it can never create a hazard.
  function automatic logic src_hits_rd(input logic use_src,
                                       input logic [REG_W-1:0] src,
                                       input logic [REG_W-1:0] rd);
    return use_src && (src == rd) && (rd != '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_flush_ctrl_load_use_detect.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_use_detect : combinational load-use hazard compare              |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module load_use_detect
  import cpu_ctrl_pkg::*;
(
  input  logic             i_ex_mem_read,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic [REG_W-1:0] i_id_rs1,
  input  logic [REG_W-1:0] i_id_rs2,
  input  logic             i_id_use_rs1,
  input  logic             i_id_use_rs2,
  output logic             o_hazard
);

  logic w_hit_rs1;
  logic w_hit_rs2;

  assign w_hit_rs1 = src_hits_rd(i_id_use_rs1, i_id_rs1, i_ex_rd);
  assign w_hit_rs2 = src_hits_rd(i_id_use_rs2, i_id_rs2, i_ex_rd);
  assign o_hazard  = i_ex_mem_read && (w_hit_rs1 || w_hit_rs2);

endmodule
`default_nettype wire

// File: rtl/hazard_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_flush_ctrl : 5-stage pipeline hold/flush/PC-select sequencer  |
// | Revision          : 1.0                                              |
// +----------------------------------------------------------------------+
module hazard_flush_ctrl
  import cpu_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_CPU,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_use_rs1,
  input  logic             ID_use_rs2,
  input  logic             EX_valid,
  input  logic [4:0]       EX_rd,
  input  logic             EX_mem_read,
  input  logic             EX_is_jal,
  input  logic             EX_is_jalr,
  input  logic             EX_is_branch,
  input  logic             EX_is_wfi,
  input  logic             EX_is_mret,
  input  logic             EX_br_taken,
  input  logic             EX_br_pred,
  input  logic             irq_pending,
  output logic             stall_hazard,
  output logic             jump_taken,
  output logic             t_pnt,
  output logic             nt_pt,
  output logic             WFI_pc_en,
  output logic             MEIP_en,
  output logic             MEIP_end,
  output logic             ID_EX_flush,
  output logic [2:0]       pc_sel,
  output logic             bp_update,
  output logic             bp_taken,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] mispred_cnt
);

  ctrl_state_e     r_state;
  ctrl_state_e     w_state_nxt;
  logic            r_rst_q;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic    w_active;
  logic    w_load_use;
  logic    w_meip_en;
  logic    w_meip_end;
  logic    w_wfi_entry;
  logic    w_wfi_pc_en;
  logic    w_jump;
  logic    w_t_pnt;
  logic    w_nt_pt;
  logic    w_stall_hazard;
  logic    w_bp_update;
  logic    w_high_pri;
  logic    w_redirect;
  pc_sel_e w_pc_sel;

  load_use_detect u_load_use_detect (
    .i_ex_mem_read (EX_mem_read),
    .i_ex_rd       (EX_rd),
    .i_id_rs1      (ID_rs1),
    .i_id_rs2      (ID_rs2),
    .i_id_use_rs1  (ID_use_rs1),
    .i_id_use_rs2  (ID_use_rs2),
    .o_hazard      (w_load_use)
  );

  // Outputs stay quiet during reset and the first cycle after it, while
  // upstream pipeline registers are still settling out of reset.
  assign w_active = !stall_CPU && !rst && !r_rst_q;

  always_ff @(posedge clk) begin
    r_rst_q <= rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_meip_en      = 1'b0;
    w_meip_end     = 1'b0;
    w_wfi_entry    = 1'b0;
    w_wfi_pc_en    = 1'b0;
    w_jump         = 1'b0;
    w_t_pnt        = 1'b0;
    w_nt_pt        = 1'b0;
    w_stall_hazard = 1'b0;
    w_bp_update    = 1'b0;
    w_high_pri     = 1'b0;
    w_redirect     = 1'b0;
    w_pc_sel       = SEQ;

    if (w_active) begin
      w_meip_en   = irq_pending && (r_state != IRQ);
      w_meip_end  = !w_meip_en && EX_valid && EX_is_mret;
      w_wfi_entry = !w_meip_en && !w_meip_end && (r_state == RUN) &&
                    EX_valid && EX_is_wfi;
      w_wfi_pc_en = !w_meip_en && !w_meip_end &&
                    (w_wfi_entry || (r_state == SLEEP));
      w_high_pri  = w_meip_en || w_meip_end || w_wfi_pc_en;

      if (!w_high_pri && EX_valid) begin
        w_jump      = EX_is_jal || EX_is_jalr;
        w_t_pnt     = !w_jump && EX_is_branch && EX_br_taken && !EX_br_pred;
        w_nt_pt     = !w_jump && EX_is_branch && !EX_br_taken && EX_br_pred;
        w_bp_update = EX_is_branch;
      end
      w_redirect     = w_jump || w_t_pnt || w_nt_pt;
      // A redirected ID instruction is flushed anyway, so its hazard is moot.
      w_stall_hazard = !w_high_pri && !w_redirect && w_load_use;

      if (w_meip_en) begin
        w_pc_sel    = MTVEC;
        w_state_nxt = IRQ;
      end else if (w_meip_end) begin
        w_pc_sel    = MEPC;
        w_state_nxt = RUN;
      end else if (w_wfi_pc_en) begin
        w_pc_sel = HOLD;
        if (w_wfi_entry) begin
          w_state_nxt = SLEEP;
        end
      end else if (w_jump || w_t_pnt) begin
        w_pc_sel = TARGET;
      end else if (w_nt_pt) begin
        w_pc_sel = EX_PC4;
      end else if (w_stall_hazard) begin
        w_pc_sel = HOLD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_bp_update) begin
        r_br_cnt <= r_br_cnt + 1'b1;
      end
      if (w_t_pnt || w_nt_pt) begin
        r_mispred_cnt <= r_mispred_cnt + 1'b1;
      end
    end
  end

  assign stall_hazard = w_stall_hazard;
  assign jump_taken   = w_jump;
  assign t_pnt        = w_t_pnt;
  assign nt_pt        = w_nt_pt;
  assign WFI_pc_en    = w_wfi_pc_en;
  assign MEIP_en      = w_meip_en;
  assign MEIP_end     = w_meip_end;
  assign ID_EX_flush  = w_meip_en || w_meip_end || w_wfi_pc_en ||
                        w_redirect || w_stall_hazard;
  assign pc_sel       = w_pc_sel;
  assign bp_update    = w_bp_update;
  assign bp_taken     = w_bp_update && EX_br_taken;
  assign br_cnt       = r_br_cnt;
  assign mispred_cnt  = r_mispred_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_flush_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_flush_ctrl : directed self-checking bench                  |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module tb_hazard_flush_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_CPU;
  logic [4:0]  ID_rs1, ID_rs2, EX_rd;
  logic        ID_use_rs1, ID_use_rs2;
  logic        EX_valid, EX_mem_read, EX_is_jal, EX_is_jalr, EX_is_branch;
  logic        EX_is_wfi, EX_is_mret, EX_br_taken, EX_br_pred, irq_pending;
  logic        stall_hazard, jump_taken, t_pnt, nt_pt, WFI_pc_en;
  logic        MEIP_en, MEIP_end, ID_EX_flush, bp_update, bp_taken;
  logic [2:0]  pc_sel;
  logic [31:0] br_cnt, mispred_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_flush_ctrl dut (
    .clk(clk), .rst(rst), .stall_CPU(stall_CPU),
    .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
    .EX_valid(EX_valid), .EX_rd(EX_rd), .EX_mem_read(EX_mem_read),
    .EX_is_jal(EX_is_jal), .EX_is_jalr(EX_is_jalr), .EX_is_branch(EX_is_branch),
    .EX_is_wfi(EX_is_wfi), .EX_is_mret(EX_is_mret),
    .EX_br_taken(EX_br_taken), .EX_br_pred(EX_br_pred), .irq_pending(irq_pending),
    .stall_hazard(stall_hazard), .jump_taken(jump_taken), .t_pnt(t_pnt), .nt_pt(nt_pt),
    .WFI_pc_en(WFI_pc_en), .MEIP_en(MEIP_en), .MEIP_end(MEIP_end),
    .ID_EX_flush(ID_EX_flush), .pc_sel(pc_sel), .bp_update(bp_update),
    .bp_taken(bp_taken), .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    stall_CPU = 0; ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
    EX_valid = 0; EX_rd = 0; EX_mem_read = 0; EX_is_jal = 0; EX_is_jalr = 0;
    EX_is_branch = 0; EX_is_wfi = 0; EX_is_mret = 0; EX_br_taken = 0;
    EX_br_pred = 0; irq_pending = 0;
  endtask

  task automatic set_load_use();
    EX_mem_read = 1; EX_rd = 5'd5; ID_rs1 = 5'd5; ID_use_rs1 = 1;
  endtask

  task automatic test_reset();
    clr_inputs();
    rst = 1;
    tick(); tick();
    set_load_use();
    #1;
    n_checks++; if (stall_hazard !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall_hazard); end
    n_checks++; if (pc_sel !== 3'd0) begin n_fail++; $display("FAIL rst_pcsel: got %0d want 0", pc_sel); end
    n_checks++; if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_brcnt: got %0d want 0", br_cnt); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_mispred: got %0d want 0", mispred_cnt); end
    tick();
    rst = 0;
    #1;
    n_checks++; if (stall_hazard !== 1'b0) begin n_fail++; $display("FAIL post_rst_stall: got %b want 0", stall_hazard); end
    n_checks++; if (ID_EX_flush !== 1'b0) begin n_fail++; $display("FAIL post_rst_flush: got %b want 0", ID_EX_flush); end
  endtask

  task automatic test_load_use();
    tick();
    n_checks++; if (stall_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_stall: got %b want 1", stall_hazard); end
    n_checks++; if (ID_EX_flush !== 1'b1) begin n_fail++; $display("FAIL lu_flush: got %b want 1", ID_EX_flush); end
    n_checks++; if (pc_sel !== 3'd5) begin n_fail++; $display("FAIL lu_pcsel: got %0d want 5", pc_sel); end
    ID_rs1 = 5'd0; ID_use_rs1 = 0; ID_rs2 = 5'd5; ID_use_rs2 = 1;
    #1;
    n_checks++; if (stall_hazard !== 1'b1) begin n_fail++; $display("FAIL lu_rs2: got %b want 1", stall_hazard); end
    EX_rd = 5'd0; ID_rs2 = 5'd0;
    #1;
    n_checks++; if (stall_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_x0: got %b want 0", stall_hazard); end
    n_checks++; if (pc_sel !== 3'd0) begin n_fail++; $display("FAIL lu_x0_pcsel: got %0d want 0", pc_sel); end
    EX_rd = 5'd5; ID_rs2 = 5'd5; ID_use_rs2 = 0;
    #1;
    n_checks++; if (stall_hazard !== 1'b0) begin n_fail++; $display("FAIL lu_nouse: got %b want 0", stall_hazard); end
    clr_inputs();
  endtask

  task automatic test_mispredict();
    tick();
    EX_valid = 1; EX_is_branch = 1; EX_br_taken = 1; EX_br_pred = 0;
    #1;
    n_checks++; if (t_pnt !== 1'b1) begin n_fail++; $display("FAIL tpnt: got %b want 1", t_pnt); end
    n_checks++; if (pc_sel !== 3'd1) begin n_fail++; $display("FAIL tpnt_pcsel: got %0d want 1", pc_sel); end
    n_checks++; if ({bp_update, bp_taken} !== 2'b11) begin n_fail++; $display("FAIL tpnt_bp: got %b want 11", {bp_update, bp_taken}); end
    n_checks++; if (mispred_cnt !== 32'd0) begin n_fail++; $display("FAIL tpnt_mis0: got %0d want 0", mispred_cnt); end
    tick();
    n_checks++; if (mispred_cnt !== 32'd1) begin n_fail++; $display("FAIL tpnt_mis1: got %0d want 1", mispred_cnt); end
    n_checks++; if (br_cnt !== 32'd1) begin n_fail++; $display("FAIL tpnt_br1: got %0d want 1", br_cnt); end
    set_load_use();
    #1;
    n_checks++; if (stall_hazard !== 1'b0) begin n_fail++; $display("FAIL tpnt_lu_stall: got %b want 0", stall_hazard); end
    n_checks++; if ({t_pnt, ID_EX_flush} !== 2'b11) begin n_fail++; $display("FAIL tpnt_lu_flush: got %b want 11", {t_pnt, ID_EX_flush}); end
    tick();
    EX_mem_read = 0; EX_br_taken = 0; EX_br_pred = 1;
    #1;
    n_checks++; if ({nt_pt, t_pnt} !== 2'b10) begin n_fail++; $display("FAIL ntpt: got %b want 10", {nt_pt, t_pnt}); end
    n_checks++; if (pc_sel !== 3'd2) begin n_fail++; $display("FAIL ntpt_pcsel: got %0d want 2", pc_sel); end
    n_checks++; if ({bp_update, bp_taken} !== 2'b10) begin n_fail++; $display("FAIL ntpt_bp: got %b want 10", {bp_update, bp_taken}); end
    tick();
    EX_br_taken = 1;
    #1;
    n_checks++; if ({t_pnt, nt_pt, ID_EX_flush} !== 3'b000) begin n_fail++; $display("FAIL correct_pred: got %b want 000", {t_pnt, nt_pt, ID_EX_flush}); end
    n_checks++; if (bp_update !== 1'b1) begin n_fail++; $display("FAIL correct_bp: got %b want 1", bp_update); end
    tick();
    clr_inputs();
    #1;
    n_checks++; if (br_cnt !== 32'd4) begin n_fail++; $display("FAIL br_cnt4: got %0d want 4", br_cnt); end
    n_checks++; if (mispred_cnt !== 32'd3) begin n_fail++; $display("FAIL mis_cnt3: got %0d want 3", mispred_cnt); end
  endtask

  task automatic test_jump_stall();
    EX_valid = 1; EX_is_jalr = 1;
    #1;
    n_checks++; if ({jump_taken, ID_EX_flush} !== 2'b11) begin n_fail++; $display("FAIL jalr: got %b want 11", {jump_taken, ID_EX_flush}); end
    n_checks++; if (pc_sel !== 3'd1) begin n_fail++; $display("FAIL jalr_pcsel: got %0d want 1", pc_sel); end
    tick();
    EX_is_jalr = 0; EX_is_jal = 1; stall_CPU = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if ({jump_taken, ID_EX_flush, pc_sel} !== 5'b0) begin n_fail++; $display("FAIL jal_stalled%0d: got %b want 0", i, {jump_taken, ID_EX_flush, pc_sel}); end
      tick();
    end
    stall_CPU = 0;
    #1;
    n_checks++; if (jump_taken !== 1'b1) begin n_fail++; $display("FAIL jal_release: got %b want 1", jump_taken); end
    tick();
    clr_inputs();
    #1;
    n_checks++; if (jump_taken !== 1'b0) begin n_fail++; $display("FAIL jal_after: got %b want 0", jump_taken); end
  endtask

  task automatic test_wfi_irq();
    EX_valid = 1; EX_is_wfi = 1;
    #1;
    n_checks++; if ({WFI_pc_en, ID_EX_flush} !== 2'b11) begin n_fail++; $display("FAIL wfi_entry: got %b want 11", {WFI_pc_en, ID_EX_flush}); end
    n_checks++; if (pc_sel !== 3'd5) begin n_fail++; $display("FAIL wfi_pcsel: got %0d want 5", pc_sel); end
    for (int i = 0; i < 10; i++) begin
      tick();
      clr_inputs();
      if (i == 4) begin
        EX_valid = 1; EX_is_branch = 1; EX_br_taken = 1;
      end
      #1;
      n_checks++; if ({WFI_pc_en, pc_sel} !== 4'b1101) begin n_fail++; $display("FAIL sleep%0d: got %b want 1101", i, {WFI_pc_en, pc_sel}); end
      if (i == 4) begin
        n_checks++; if ({bp_update, t_pnt} !== 2'b00) begin n_fail++; $display("FAIL sleep_branch: got %b want 00", {bp_update, t_pnt}); end
      end
    end
    clr_inputs();
    irq_pending = 1;
    #1;
    n_checks++; if ({MEIP_en, WFI_pc_en, ID_EX_flush} !== 3'b101) begin n_fail++; $display("FAIL irq_wake: got %b want 101", {MEIP_en, WFI_pc_en, ID_EX_flush}); end
    n_checks++; if (pc_sel !== 3'd3) begin n_fail++; $display("FAIL irq_pcsel: got %0d want 3", pc_sel); end
    n_checks++; if (br_cnt !== 32'd4) begin n_fail++; $display("FAIL sleep_brcnt: got %0d want 4", br_cnt); end
    tick();
    n_checks++; if ({MEIP_en, WFI_pc_en, pc_sel} !== 5'b0) begin n_fail++; $display("FAIL irq_nonest: got %b want 0", {MEIP_en, WFI_pc_en, pc_sel}); end
    EX_valid = 1; EX_is_mret = 1;
    #1;
    n_checks++; if ({MEIP_end, MEIP_en} !== 2'b10) begin n_fail++; $display("FAIL mret: got %b want 10", {MEIP_end, MEIP_en}); end
    n_checks++; if (pc_sel !== 3'd4) begin n_fail++; $display("FAIL mret_pcsel: got %0d want 4", pc_sel); end
    tick();
    clr_inputs();
    irq_pending = 1; EX_valid = 1; EX_is_wfi = 1;
    #1;
    n_checks++; if ({MEIP_en, WFI_pc_en} !== 2'b10) begin n_fail++; $display("FAIL irq_wfi: got %b want 10", {MEIP_en, WFI_pc_en}); end
    n_checks++; if (pc_sel !== 3'd3) begin n_fail++; $display("FAIL irq_wfi_pcsel: got %0d want 3", pc_sel); end
    tick();
    clr_inputs();
    EX_valid = 1; EX_is_mret = 1; set_load_use();
    #1;
    n_checks++; if ({MEIP_end, stall_hazard, WFI_pc_en} !== 3'b100) begin n_fail++; $display("FAIL mret_lu: got %b want 100", {MEIP_end, stall_hazard, WFI_pc_en}); end
    n_checks++; if (pc_sel !== 3'd4) begin n_fail++; $display("FAIL mret_lu_pcsel: got %0d want 4", pc_sel); end
    tick();
    clr_inputs();
    #1;
    n_checks++; if ({WFI_pc_en, MEIP_end, pc_sel} !== 5'b0) begin n_fail++; $display("FAIL back_in_run: got %b want 0", {WFI_pc_en, MEIP_end, pc_sel}); end
  endtask

  task automatic test_reset_in_sleep();
    rst = 1;
    tick();
    rst = 0;
    tick();
    EX_valid = 1; EX_is_branch = 1; EX_br_taken = 1; EX_br_pred = 1;
    repeat (7) tick();
    clr_inputs();
    #1;
    n_checks++; if (br_cnt !== 32'd7) begin n_fail++; $display("FAIL br_cnt7: got %0d want 7", br_cnt); end
    EX_valid = 1; EX_is_wfi = 1;
    tick();
    clr_inputs();
    tick();
    n_checks++; if (WFI_pc_en !== 1'b1) begin n_fail++; $display("FAIL pre_rst_sleep: got %b want 1", WFI_pc_en); end
    rst = 1;
    #1;
    n_checks++; if ({WFI_pc_en, pc_sel} !== 4'b0) begin n_fail++; $display("FAIL rst_gate: got %b want 0", {WFI_pc_en, pc_sel}); end
    tick();
    rst = 0;
    #1;
    n_checks++; if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL rst_sleep_br: got %0d want 0", br_cnt); end
    tick();
    n_checks++; if ({WFI_pc_en, pc_sel} !== 4'b0) begin n_fail++; $display("FAIL rst_sleep_run: got %b want 0", {WFI_pc_en, pc_sel}); end
  endtask

  task automatic test_wrap();
    force dut.r_br_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.r_br_cnt;
    EX_valid = 1; EX_is_branch = 1; EX_br_taken = 1; EX_br_pred = 1;
    #1;
    n_checks++; if (br_cnt !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL wrap_pre: got %h want ffffffff", br_cnt); end
    tick();
    clr_inputs();
    #1;
    n_checks++; if (br_cnt !== 32'd0) begin n_fail++; $display("FAIL wrap: got %h want 00000000", br_cnt); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_mispredict();
    test_jump_stall();
    test_wfi_irq();
    test_reset_in_sleep();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/hazard_flush_ctrl.md
# hazard_flush_ctrl

Central pipeline sequencing controller for the 5-stage CPU. It drives the hold/flush controls of the IF/ID and ID/EX pipeline registers, and the PC-select mux. It resolves four things each cycle: load-use hazards, jump/branch-misprediction redirects, WFI sleep, and machine-external-interrupt entry/return. It also keeps branch statistics counters.

## Interface
Parameters:
- none

Ports:
- `clk` in 1 — clock
- `rst` in 1 — reset; synchronous, active-high
- `stall_CPU` in 1 — memory-system stall; freezes the whole pipeline
- `ID_rs1`, `ID_rs2` in 5 — source registers of the instruction in ID
- `ID_use_rs1`, `ID_use_rs2` in 1 — the ID instruction actually reads that source
- `EX_valid` in 1 — EX holds a real (non-bubble) instruction
- `EX_rd` in 5 — destination register of the EX instruction
- `EX_mem_read` in 1 — the EX instruction is a load
- `EX_is_jal`, `EX_is_jalr`, `EX_is_branch`, `EX_is_wfi`, `EX_is_mret` in 1 — EX instruction class
- `EX_br_taken` in 1 — branch outcome resolved in EX
- `EX_br_pred` in 1 — prediction carried with the EX instruction
- `irq_pending` in 1 — MEIP & mie.MEIE & mstatus.MIE, from the CSR file
- `stall_hazard` out 1 — hold IF/ID and PC; insert bubble into ID/EX
- `jump_taken`, `t_pnt`, `nt_pt` out 1 — redirect causes, one-hot or zero
- `WFI_pc_en` out 1 — hold PC, flush IF/ID (WFI)
- `MEIP_en` out 1 — interrupt entry pulse
- `MEIP_end` out 1 — trap return pulse
- `ID_EX_flush` out 1 — bubble ID/EX
- `pc_sel` out 3 — `pc_sel_e` value
- `bp_update` out 1 — train the predictor
- `bp_taken` out 1 — resolved direction used for training
- `br_cnt` out 32 — branch count
- `mispred_cnt` out 32 — misprediction count

## Operation
- States: `RUN`, `SLEEP`, `IRQ`. The state is registered. Reset state is `RUN`.
- Every event output is combinational from inputs and state, and is forced to 0 while `stall_CPU=1`. The FSM and counters also hold while `stall_CPU=1`. Each EX event therefore produces exactly one pulse, in the first unstalled cycle.
- Priority, highest first, evaluated when `!stall_CPU`:
  1. `MEIP_en`. Asserted if `irq_pending` and the state is `RUN` or `SLEEP`. Next state is `IRQ`. `pc_sel=MTVEC`. The EX instruction is squashed.
  2. `MEIP_end`. Asserted if `EX_valid & EX_is_mret`, in any state. Next state is `RUN`. `pc_sel=MEPC`.
  3. WFI entry. Asserted if the state is `RUN` and `EX_valid & EX_is_wfi`. Next state is `SLEEP`.
  4. Redirect, only if `EX_valid`:
     - `jump_taken` for jal/jalr, with `pc_sel=TARGET`.
     - `t_pnt` for a branch with `taken & !pred`, with `pc_sel=TARGET`.
     - `nt_pt` for a branch with `!taken & pred`, with `pc_sel=EX_PC4`.
  5. `stall_hazard`. Asserted if `EX_mem_read & EX_rd!=0 & ((ID_use_rs1 & ID_rs1==EX_rd) | (ID_use_rs2 & ID_rs2==EX_rd))`. `pc_sel=HOLD`.
  6. Otherwise `pc_sel=SEQ` (PC+4 or predicted target).
- A higher-priority event suppresses every lower one in the same cycle.
- A redirect suppresses `stall_hazard`, because the ID instruction is being flushed anyway.
- `WFI_pc_en` is 1 in the WFI-entry cycle and in every `SLEEP` cycle, unless `MEIP_en` fires. In those cycles `pc_sel=HOLD`.
- `IRQ` state: `irq_pending` is ignored (no nesting). Only `MEIP_end` leaves `IRQ`.
- `ID_EX_flush` = `MEIP_en | MEIP_end | WFI_pc_en | jump_taken | t_pnt | nt_pt | stall_hazard`.
- `bp_update=1` for every valid unstalled branch that is not suppressed by priority 1–3. `bp_taken=EX_br_taken`.
- Counters:
  - `br_cnt` increments on `bp_update`.
  - `mispred_cnt` increments on `t_pnt|nt_pt`.
  - Both are 32-bit and wrap modulo 2^32.

## Timing
- Control outputs: zero latency, combinational in the same cycle.
- State and counters update on the rising edge of `clk`.
- All outputs are 0 whenever `stall_CPU=1`. During reset and the cycle after, outputs are 0 except `pc_sel=SEQ`.
- `rst` sampled high: state becomes `RUN` and both counters become 0 on that edge, even mid-`SLEEP` or mid-`IRQ`.
- `irq_pending` rising in the same cycle as EX=WFI: `MEIP_en` only, and no `SLEEP` is entered.
- mret and a load-use in the same cycle: `MEIP_end` only.
- `br_cnt` at 0xFFFFFFFF plus one branch gives 0.

## Structure
- Package `cpu_ctrl_pkg`:
  - `ctrl_state_e` {`RUN`, `SLEEP`, `IRQ`}.
  - `pc_sel_e` 3-bit {`SEQ=0`, `TARGET=1`, `EX_PC4=2`, `MTVEC=3`, `MEPC=4`, `HOLD=5`}.
- One natural sub-module: `load_use_detect`, the combinational hazard compare.

## Test plan
- `EX_mem_read=1`, `EX_rd=5`, `ID_rs1=5`, `ID_use_rs1=1` → `stall_hazard=1`, `ID_EX_flush=1`, `pc_sel=5` for one cycle. The same case with `EX_rd=0` gives `stall_hazard=0`.
- Branch with `taken=1`, `pred=0` → `t_pnt=1`, `pc_sel=1`, `mispred_cnt` 0→1, `br_cnt` 0→1. Adding a simultaneous load-use gives `stall_hazard=0`.
- WFI in EX → `WFI_pc_en=1` and the state is `SLEEP` for 10 cycles. `irq_pending=1` then gives `MEIP_en=1`, `pc_sel=3`, `WFI_pc_en=0`, and next state `IRQ`.
- In `IRQ` with `irq_pending=1` → no `MEIP_en`. mret in EX → `MEIP_end=1`, `pc_sel=4`, and next state `RUN`.
- jal in EX with `stall_CPU=1` for 3 cycles → `jump_taken=0` for all 3 cycles, then `jump_taken=1` for exactly 1 cycle after release.
- `rst=1` for one edge while in `SLEEP` with `br_cnt=7` → state `RUN` and `br_cnt=0`.
